// File: rtl/mono_fb_arbiter_if.sv
// Bus bundle for mono_fb_arbiter: pixel ingress, scanout read handshake,
// framebuffer RAM port and status outputs.
interface mono_fb_if #(
  parameter int ADDR_BITS = 14
) ();
  logic [15:0]          wr_bits;
  logic [11:0]          wr_xaddr;
  logic [11:0]          wr_yaddr;
  logic                 wr_strobe;
  logic                 vsync;
  logic                 rd_req;
  logic [ADDR_BITS-1:0] rd_addr;
  logic                 rd_ready;
  logic                 rd_valid;
  logic [15:0]          rd_data;
  logic [ADDR_BITS-1:0] ram_addr;
  logic [15:0]          ram_wdata;
  logic                 ram_we;
  logic [15:0]          ram_rdata;
  logic [15:0]          overflow_count;
  logic                 clearing;

  modport slave (
    input  wr_bits, wr_xaddr, wr_yaddr, wr_strobe, vsync, rd_req, rd_addr, ram_rdata,
    output rd_ready, rd_valid, rd_data, ram_addr, ram_wdata, ram_we, overflow_count, clearing
  );

  modport master (
    output wr_bits, wr_xaddr, wr_yaddr, wr_strobe, vsync, rd_req, rd_addr, ram_rdata,
    input  rd_ready, rd_valid, rd_data, ram_addr, ram_wdata, ram_we, overflow_count, clearing
  );
endinterface

// File: rtl/mono_fb_arbiter.sv
// Framebuffer port arbiter: pixel-word write FIFO vs. scanout reads, reads first,
// with a starvation timer for writes. Define MONO_FB_CLEAR_EN for a post-reset clear sweep.
module mono_fb_arbiter #(
  parameter int WIDTH      = 512,
  parameter int HEIGHT     = 342,
  parameter int ADDR_BITS  = 14,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WAIT   = 15
) (
  input logic      clk,
  input logic      reset_n,
  mono_fb_if.slave bus
);

  localparam int SHIFT  = $clog2(WIDTH / 16);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [12:0]       X_LIM    = 13'(WIDTH);
  localparam logic [12:0]       Y_LIM    = 13'(HEIGHT);

  logic [ADDR_BITS-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [15:0]          r_fifo_data [FIFO_DEPTH];
  logic [PTR_W:0]       r_wptr;
  logic [PTR_W:0]       r_rptr;
  logic [WAIT_W-1:0]    r_wait;
  logic                 r_rd_valid;
  logic [15:0]          r_ovf;

  logic                 w_empty;
  logic                 w_full;
  logic                 w_force;
  logic                 w_pop;
  logic                 w_rd_grant;
  logic                 w_we;
  logic                 w_in_range;
  logic                 w_accept_in;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_clear_active;
  logic [ADDR_BITS-1:0] w_ram_addr;
  logic [ADDR_BITS-1:0] w_wr_addr;
  logic [ADDR_BITS-1:0] w_clr_addr;
  logic [15:0]          w_ram_wdata;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]) && (r_wptr[PTR_W] != r_rptr[PTR_W]);
  assign w_force = (r_wait == WAIT_MAX) && !w_empty;

  // WIDTH is a power of two, so the line stride multiply reduces to a shift
  assign w_wr_addr   = ADDR_BITS'(({12'd0, bus.wr_yaddr} << SHIFT) + {16'd0, bus.wr_xaddr[11:4]});
  assign w_in_range  = ({1'b0, bus.wr_xaddr} < X_LIM) && ({1'b0, bus.wr_yaddr} < Y_LIM);
  assign w_accept_in = bus.wr_strobe && w_in_range && !w_clear_active;
  // a pop in the same cycle frees the slot, so a push into a full FIFO survives
  assign w_push      = w_accept_in && (!w_full || w_pop);
  assign w_drop      = w_accept_in && w_full && !w_pop;

  // RAM port arbitration: clear sweep, forced write, read, opportunistic write, idle
  always_comb begin
    w_pop       = 1'b0;
    w_rd_grant  = 1'b0;
    w_we        = 1'b0;
    w_ram_addr  = {ADDR_BITS{1'b0}};
    w_ram_wdata = 16'h0000;
    if (!reset_n) begin
      w_we = 1'b0;
    end else if (w_clear_active) begin
      w_we       = 1'b1;
      w_ram_addr = w_clr_addr;
    end else if (w_force) begin
      w_pop       = 1'b1;
      w_we        = 1'b1;
      w_ram_addr  = r_fifo_addr[r_rptr[PTR_W-1:0]];
      w_ram_wdata = r_fifo_data[r_rptr[PTR_W-1:0]];
    end else if (bus.rd_req) begin
      w_rd_grant = 1'b1;
      w_ram_addr = bus.rd_addr;
    end else if (!w_empty) begin
      w_pop       = 1'b1;
      w_we        = 1'b1;
      w_ram_addr  = r_fifo_addr[r_rptr[PTR_W-1:0]];
      w_ram_wdata = r_fifo_data[r_rptr[PTR_W-1:0]];
    end else begin
      w_we = 1'b0;
    end
  end

  // write FIFO storage and pointers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= {(PTR_W+1){1'b0}};
      r_rptr <= {(PTR_W+1){1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_addr[i] <= {ADDR_BITS{1'b0}};
        r_fifo_data[i] <= 16'h0000;
      end
    end else begin
      if (w_push) begin
        r_fifo_addr[r_wptr[PTR_W-1:0]] <= w_wr_addr;
        r_fifo_data[r_wptr[PTR_W-1:0]] <= bus.wr_bits;
        r_wptr <= r_wptr + (PTR_W+1)'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + (PTR_W+1)'(1);
      end
    end
  end

  // starvation timer, read-valid pipeline and per-frame drop counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait     <= {WAIT_W{1'b0}};
      r_rd_valid <= 1'b0;
      r_ovf      <= 16'h0000;
    end else begin
      r_rd_valid <= w_rd_grant;
      if (w_rd_grant) begin
        if (!w_empty && (r_wait != WAIT_MAX)) begin
          r_wait <= r_wait + WAIT_W'(1);
        end
      end else begin
        r_wait <= {WAIT_W{1'b0}};
      end
      if (bus.vsync) begin
        r_ovf <= w_drop ? 16'h0001 : 16'h0000;
      end else if (w_drop && (r_ovf != 16'hFFFF)) begin
        r_ovf <= r_ovf + 16'h0001;
      end
    end
  end

`ifdef MONO_FB_CLEAR_EN
  typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;
  localparam logic [ADDR_BITS-1:0] CLR_LAST = ADDR_BITS'(HEIGHT * WIDTH / 16 - 1);

  state_t               r_state;
  logic [ADDR_BITS-1:0] r_clr_addr;

  // post-reset sweep zeroing every visible framebuffer word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= {ADDR_BITS{1'b0}};
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (r_clr_addr == CLR_LAST) begin
            r_state    <= ST_RUN;
            r_clr_addr <= {ADDR_BITS{1'b0}};
          end else begin
            r_clr_addr <= r_clr_addr + ADDR_BITS'(1);
          end
        end
        ST_RUN:  r_state <= ST_RUN;
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign w_clear_active = reset_n && (r_state == ST_CLEAR);
  assign w_clr_addr     = r_clr_addr;
`else
  assign w_clear_active = 1'b0;
  assign w_clr_addr     = {ADDR_BITS{1'b0}};
`endif

  assign bus.rd_ready       = w_rd_grant;
  assign bus.ram_we         = w_we;
  assign bus.ram_addr       = w_ram_addr;
  assign bus.ram_wdata      = w_ram_wdata;
  assign bus.rd_valid       = r_rd_valid;
  assign bus.rd_data        = bus.ram_rdata;
  assign bus.overflow_count = r_ovf;
  assign bus.clearing       = w_clear_active;

endmodule

// File: tb/tb_mono_fb_arbiter.sv
// Scoreboard bench for mono_fb_arbiter: a queue-based reference model predicts
// grants, RAM writes and read data; a separate monitor checks what the DUT presents.
module tb_mono_fb_arbiter;
  localparam int WIDTH = 512, HEIGHT = 342, ADDR_BITS = 14, FIFO_DEPTH = 4, MAX_WAIT = 15;
  localparam int WORDS = HEIGHT * WIDTH / 16;
`ifdef MONO_FB_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [ADDR_BITS-1:0] a;
    logic [15:0]          d;
  } ent_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  mono_fb_if #(.ADDR_BITS(ADDR_BITS)) bus ();

  mono_fb_arbiter #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_BITS(ADDR_BITS),
    .FIFO_DEPTH(FIFO_DEPTH), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] seed_word(int i);
    return 16'(i * 40503 + 7);
  endfunction

  function automatic logic [ADDR_BITS-1:0] pix_addr(int x, int y);
    return ADDR_BITS'((y * (WIDTH / 16) + x / 16) % (1 << ADDR_BITS));
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // synchronous RAM behind the DUT
  logic [15:0] ram [0:(1<<ADDR_BITS)-1];
  bit ram_inited = 1'b0;
  always @(posedge clk) begin
    if (!ram_inited) begin
      for (int i = 0; i < (1 << ADDR_BITS); i++) ram[i] <= seed_word(i);
      ram_inited <= 1'b1;
    end else begin
      if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata <= ram[bus.ram_addr];
    end
  end

  // reference model state
  ent_t        mq[$];
  ent_t        exp_wr[$];
  logic [15:0] exp_rd[$];
  logic [15:0] ref_mem [0:(1<<ADDR_BITS)-1];
  bit          ref_inited = 1'b0;
  int          mwait = 0;
  int          movf = 0;
  int          clear_left = 0;

  // model: predict this cycle's grant and push expected responses
  always @(negedge clk) begin
    bit   wr_g, rd_g, drop;
    ent_t e;
    if (!ref_inited) begin
      for (int i = 0; i < (1 << ADDR_BITS); i++) ref_mem[i] = seed_word(i);
      ref_inited = 1'b1;
    end
    if (!reset_n) begin
      chk("rst_rd_ready", bus.rd_ready, 0);
      chk("rst_ram_we", bus.ram_we, 0);
      chk("rst_rd_valid", bus.rd_valid, 0);
      chk("rst_overflow", bus.overflow_count, 0);
      chk("rst_clearing", bus.clearing, 0);
      mq.delete();
      exp_rd.delete();
      exp_wr.delete();
      mwait = 0;
      movf = 0;
      clear_left = CLEAR_EN ? WORDS : 0;
    end else begin
      chk("clearing", bus.clearing, (clear_left > 0));
      chk("overflow", bus.overflow_count, movf);
      wr_g = 1'b0;
      rd_g = 1'b0;
      if (clear_left > 0) begin
        e.a = ADDR_BITS'(WORDS - clear_left);
        e.d = 16'h0000;
        exp_wr.push_back(e);
        ref_mem[e.a] = 16'h0000;
        clear_left--;
        if (bus.vsync) movf = 0;
      end else begin
        if (mwait == MAX_WAIT && mq.size() > 0) wr_g = 1'b1;
        else if (bus.rd_req) rd_g = 1'b1;
        else if (mq.size() > 0) wr_g = 1'b1;
        if (rd_g) begin
          if (mq.size() > 0 && mwait < MAX_WAIT) mwait++;
        end else begin
          mwait = 0;
        end
        if (wr_g) begin
          e = mq.pop_front();
          exp_wr.push_back(e);
          ref_mem[e.a] = e.d;
        end
        if (rd_g) exp_rd.push_back(ref_mem[bus.rd_addr]);
        drop = 1'b0;
        if (bus.wr_strobe && bus.wr_xaddr < WIDTH && bus.wr_yaddr < HEIGHT) begin
          if (mq.size() < FIFO_DEPTH) begin
            e.a = pix_addr(bus.wr_xaddr, bus.wr_yaddr);
            e.d = bus.wr_bits;
            mq.push_back(e);
          end else begin
            drop = 1'b1;
          end
        end
        if (bus.vsync) movf = drop ? 1 : 0;
        else if (drop && movf < 65535) movf++;
      end
      chk("rd_ready", bus.rd_ready, rd_g);
    end
  end

  // monitor: pop expectations whenever the DUT writes RAM or returns read data
  always @(negedge clk) begin
    ent_t e;
    #2;
    if (reset_n) begin
      if (bus.ram_we) begin
        if (exp_wr.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected none", bus.ram_addr, bus.ram_wdata);
        end else begin
          e = exp_wr.pop_front();
          chk("wr_addr", bus.ram_addr, e.a);
          chk("wr_data", bus.ram_wdata, e.d);
        end
      end
      if (bus.rd_valid) begin
        if (exp_rd.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rd_valid: got rd_data %0h expected no valid", bus.rd_data);
        end else begin
          chk("rd_data", bus.rd_data, exp_rd.pop_front());
        end
      end
    end
  end

  task automatic drive(bit s, logic [15:0] b, int x, int y, bit v, bit rq, int ra);
    @(posedge clk);
    #1;
    bus.wr_strobe = s;
    bus.wr_bits   = b;
    bus.wr_xaddr  = 12'(x);
    bus.wr_yaddr  = 12'(y);
    bus.vsync     = v;
    bus.rd_req    = rq;
    bus.rd_addr   = ADDR_BITS'(ra);
  endtask

  task automatic idle(int n, bit rq);
    for (int i = 0; i < n; i++) drive(1'b0, 16'h0000, 0, 0, 1'b0, rq, 7);
  endtask

  task automatic random_run(int n);
    bit granted = 1'b1;
    bit rq = 1'b0;
    int ra = 0;
    int last_wa = 0;
    for (int i = 0; i < n; i++) begin
      bit s;
      int x, y;
      s = ($urandom_range(0, 2) == 0);
      x = ($urandom_range(0, 9) == 0) ? int'($urandom_range(512, 700)) : int'($urandom_range(0, 511));
      y = ($urandom_range(0, 9) == 0) ? int'($urandom_range(342, 400)) : int'($urandom_range(0, 341));
      if (!(rq && !granted)) begin
        rq = ($urandom_range(0, 3) != 0);
        ra = ($urandom_range(0, 2) == 0) ? last_wa : int'($urandom_range(0, WORDS - 1));
      end
      if (s && x < WIDTH && y < HEIGHT) last_wa = int'(pix_addr(x, y));
      drive(s, 16'($urandom), x, y, ($urandom_range(0, 99) == 0), rq, ra);
      @(negedge clk);
      #1;
      granted = bus.rd_ready;
    end
  endtask

  initial begin
    bus.wr_strobe = 1'b0; bus.wr_bits = 16'h0000; bus.wr_xaddr = 12'd0; bus.wr_yaddr = 12'd0;
    bus.vsync = 1'b0; bus.rd_req = 1'b1; bus.rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    bus.rd_req = 1'b0;
    if (CLEAR_EN) idle(WORDS + 3, 1'b1);
    idle(3, 1'b0);

    // single write, then out-of-range strobes
    drive(1'b1, 16'hA5A5, 32, 1, 1'b0, 1'b0, 0);
    idle(2, 1'b0);
    drive(1'b1, 16'h1111, 512, 0, 1'b0, 1'b0, 0);
    drive(1'b1, 16'h2222, 0, 342, 1'b0, 1'b0, 0);
    idle(2, 1'b0);

    // reads starve one queued write for MAX_WAIT grants, then read it back
    drive(1'b1, 16'h5A5A, 48, 2, 1'b0, 1'b1, 66);
    idle(20, 1'b1);
    idle(2, 1'b0);

    // six back-to-back strobes under constant reads: two drops, then vsync clears
    for (int i = 0; i < 6; i++) drive(1'b1, 16'(16'hC000 + i), i * 16, 10, 1'b0, 1'b1, 320);
    idle(70, 1'b1);
    drive(1'b0, 16'h0000, 0, 0, 1'b1, 1'b0, 0);
    idle(3, 1'b0);

    // full FIFO plus strobe on the cycle the first write is granted
    for (int i = 0; i < 4; i++) drive(1'b1, 16'(16'h7000 + i), i * 16, 20, 1'b0, 1'b1, 640);
    drive(1'b1, 16'h7777, 64, 20, 1'b0, 1'b0, 0);
    idle(8, 1'b0);

    random_run(3000);
    idle(12, 1'b0);

    // asynchronous reset with queued writes and a read in flight
    for (int i = 0; i < 3; i++) drive(1'b1, 16'(16'h3300 + i), i * 16, 30, 1'b0, 1'b1, 5);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    bus.wr_strobe = 1'b0;
    bus.rd_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    if (CLEAR_EN) idle(WORDS + 3, 1'b1);
    random_run(500);
    idle(30, 1'b0);

    chk("pending_writes", exp_wr.size(), 0);
    chk("pending_reads", exp_rd.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mono_fb_arbiter.md
Name: mono_fb_arbiter

Overview:
- Sits in the mono_clk domain, after the dither/clock-crossing stage and in front of a single-port 16-bit-word framebuffer RAM.
- Buffers incoming 16-pixel mono words (base x/y address plus strobe) in a small FIFO and converts the coordinates to RAM word addresses.
- Arbitrates the one RAM port between these writes and the display scanout reader. Reads have priority; an anti-starvation timer protects the writes.

Parameters:
- WIDTH, 512, active pixels per line; must be a power of two and a multiple of 16.
- HEIGHT, 342, active lines.
- ADDR_BITS, 14, RAM word-address width; must satisfy 2^ADDR_BITS >= HEIGHT*WIDTH/16.
- FIFO_DEPTH, 4, write FIFO entries; must be a power of two, at least 2.
- MAX_WAIT, 15, consecutive cycles a non-empty FIFO may go unserved before writes take priority.

Ports:
- clk  in  1  mono_clk; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wr_bits  in  16  mono pixel word; bit 15 is the leftmost pixel.
- wr_xaddr  in  12  base x of the word; bits [3:0] are ignored.
- wr_yaddr  in  12  line number.
- wr_strobe  in  1  one-cycle pulse: word valid; no backpressure.
- vsync  in  1  one-cycle frame-start pulse.
- rd_req  in  1  scanout read request; held until granted.
- rd_addr  in  ADDR_BITS  word address to read.
- rd_ready  out  1  read granted this cycle (combinational).
- rd_valid  out  1  rd_data valid; registered, one cycle after grant.
- rd_data  out  16  read data; follows ram_rdata.
- ram_addr  out  ADDR_BITS  RAM address (combinational from the grant).
- ram_wdata  out  16  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_rdata  in  16  RAM synchronous read data; one-cycle latency.
- overflow_count  out  16  words dropped this frame; saturates.
- clearing  out  1  clear sweep in progress.

Behaviour:
- Reset: FIFO empty, wait counter 0, rd_valid 0, overflow_count 0, clearing 0; ram_we 0 and rd_ready 0 while reset is held.
- Ingress:
  - On wr_strobe, drop the word (not counted) if wr_xaddr >= WIDTH or wr_yaddr >= HEIGHT.
  - Otherwise push {addr, bits}, with addr = wr_yaddr*(WIDTH/16) + wr_xaddr[11:4], truncated to ADDR_BITS. The multiply is a shift.
- FIFO full:
  - A push while full drops the word and increments overflow_count, saturating at 16'hFFFF.
  - Pop and push in the same cycle while full: the pop is taken first, so the push is accepted and nothing is dropped.
- vsync: overflow_count <= 0. If vsync coincides with a drop, overflow_count <= 1.
- Arbitration, evaluated each cycle:
  - Write-force condition: wait counter == MAX_WAIT and FIFO non-empty.
  - If the write-force condition holds: pop the FIFO; ram_we=1, ram_addr/ram_wdata = head entry; rd_ready=0; wait counter <= 0.
  - Else if rd_req: rd_ready=1, ram_we=0, ram_addr=rd_addr; if FIFO non-empty, wait counter +1.
  - Else if FIFO non-empty: pop and write; wait counter <= 0.
  - Else: idle, ram_we=0, ram_addr=0; wait counter <= 0.
- Read data: rd_valid <= rd_ready; rd_data = ram_rdata whenever rd_valid=1.
- A read after a write to the same address in the next cycle returns the new data, because RAM accesses are serialised.
- Wait counter saturates at MAX_WAIT and is cleared on every write grant.
- Asynchronous reset mid-operation: FIFO contents are discarded; any in-flight rd_valid is cancelled.

Optional Feature:
- Macro: MONO_FB_CLEAR_EN.
- Defined: after reset deassertion, the block enters state CLEAR.
  - clearing=1; writes 16'h0000 to addresses 0..(HEIGHT*WIDTH/16 - 1), one per cycle, with ram_we=1.
  - rd_ready=0 throughout the sweep; wr_strobe words are dropped and not counted.
  - After the last address, the block goes to RUN and clearing=0.
  - Sweep length at defaults: 10944 cycles.
- Undefined: the block starts directly in RUN; clearing is tied to 0.

Test Plan:
- Strobe bits=16'hA5A5, x=32, y=1, rd_req low -> next cycle ram_we=1, ram_addr=34, ram_wdata=16'hA5A5.
- Strobe x=512, y=0 and strobe x=0, y=342 -> no RAM write; overflow_count stays 0.
- rd_req held high with one queued write -> 15 read grants, then one cycle with rd_ready=0 and ram_we=1, then reads resume; rd_valid follows each grant by 1 cycle.
- rd_req high constantly, 6 strobes on consecutive cycles with FIFO_DEPTH=4 -> 2 dropped, overflow_count=2; then vsync -> overflow_count=0.
- Full FIFO, strobe in the same cycle as a write grant -> accepted; overflow_count unchanged.
- With MONO_FB_CLEAR_EN: release reset -> clearing=1 for 10944 cycles with ram_addr counting 0..10943 and ram_wdata=0; rd_req is ignored during the sweep and granted on the first cycle afterwards.
